// File: rtl/dft_axil_pkg.sv
// Shared types and constants for the DFT AXI4-Lite slave front end.
package dft_axil_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   // Transaction sequencer states.
   typedef enum logic [2:0] {
      IDLE,
      WR,
      BRESP,
      RD,
      RLAT,
      RRESP
   } state_e;

endpackage

// File: rtl/dft_axil_slave.sv
// AXI4-Lite slave front end for the DFT accelerator.
// Converts AXI4-Lite reads/writes into a single-issue, word-addressed
// register bus with one-cycle read latency.
// Ports:
//   AXI_S_ACLK / AXI_S_ARESETn : clock, synchronous active-low reset
//   AXI_S_AW* / AXI_S_W*       : write address / data channels
//   AXI_S_B*                   : write response channel (always OKAY)
//   AXI_S_AR* / AXI_S_R*       : read address / data channels
//   reg_wr_en / reg_rd_en      : one-cycle strobes to the register file
//   reg_addr / reg_wdata / reg_wstrb : register bus payload
//   reg_rdata                  : read data, valid the cycle after reg_rd_en
module dft_axil_slave
   import dft_axil_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 24,
   parameter int unsigned REG_AW     = ADDR_WIDTH - 2
) (
   input  logic                  AXI_S_ACLK,
   input  logic                  AXI_S_ARESETn,
   input  logic                  AXI_S_AWVALID,
   output logic                  AXI_S_AWREADY,
   input  logic [ADDR_WIDTH-1:0] AXI_S_AWADDR,
   input  logic [2:0]            AXI_S_AWPROT,
   input  logic                  AXI_S_WVALID,
   output logic                  AXI_S_WREADY,
   input  logic [DATA_W-1:0]     AXI_S_WDATA,
   input  logic [STRB_W-1:0]     AXI_S_WSTRB,
   output logic                  AXI_S_BVALID,
   input  logic                  AXI_S_BREADY,
   output logic [1:0]            AXI_S_BRESP,
   input  logic                  AXI_S_ARVALID,
   output logic                  AXI_S_ARREADY,
   input  logic [ADDR_WIDTH-1:0] AXI_S_ARADDR,
   input  logic [2:0]            AXI_S_ARPROT,
   output logic                  AXI_S_RVALID,
   input  logic                  AXI_S_RREADY,
   output logic [DATA_W-1:0]     AXI_S_RDATA,
   output logic [1:0]            AXI_S_RRESP,
   output logic                  reg_wr_en,
   output logic                  reg_rd_en,
   output logic [REG_AW-1:0]     reg_addr,
   output logic [DATA_W-1:0]     reg_wdata,
   output logic [STRB_W-1:0]     reg_wstrb,
   input  logic [DATA_W-1:0]     reg_rdata
);

   state_e              state_q, state_d;
   logic                run_q;
   logic                aw_full_q, aw_full_d;
   logic                w_full_q, w_full_d;
   logic [REG_AW-1:0]   aw_addr_q, aw_addr_d;
   logic [DATA_W-1:0]   w_data_q, w_data_d;
   logic [STRB_W-1:0]   w_strb_q, w_strb_d;
   logic                awready_q, awready_d;
   logic                wready_q, wready_d;
   logic                arready_q, arready_d;
   logic                bvalid_q, bvalid_d;
   logic                rvalid_q, rvalid_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                wr_en_q, wr_en_d;
   logic                rd_en_q, rd_en_d;
   logic [REG_AW-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic                aw_hs, w_hs, ar_hs;

   // Protection bits and byte offsets carry no meaning for a word register bus.
   logic unused_inputs;
   assign unused_inputs = ^{AXI_S_AWPROT, AXI_S_ARPROT, AXI_S_AWADDR[1:0], AXI_S_ARADDR[1:0]};

   // State and output registers.
   always_ff @(posedge AXI_S_ACLK) begin
      if (!AXI_S_ARESETn) begin
         state_q   <= IDLE;
         run_q     <= 1'b0;
         aw_full_q <= 1'b0;
         w_full_q  <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         arready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         state_q   <= state_d;
         run_q     <= 1'b1;
         aw_full_q <= aw_full_d;
         w_full_q  <= w_full_d;
         aw_addr_q <= aw_addr_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         arready_q <= arready_d;
         bvalid_q  <= bvalid_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      aw_hs     = run_q & AXI_S_AWVALID & awready_q;
      w_hs      = run_q & AXI_S_WVALID & wready_q;
      ar_hs     = run_q & AXI_S_ARVALID & arready_q;

      state_d   = state_q;
      aw_full_d = aw_full_q | aw_hs;
      w_full_d  = w_full_q | w_hs;
      aw_addr_d = aw_hs ? REG_AW'(AXI_S_AWADDR[ADDR_WIDTH-1:2]) : aw_addr_q;
      w_data_d  = w_hs ? AXI_S_WDATA : w_data_q;
      w_strb_d  = w_hs ? AXI_S_WSTRB : w_strb_q;
      bvalid_d  = 1'b0;
      rvalid_d  = 1'b0;
      rdata_d   = rdata_q;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;

      case (state_q)
         IDLE: begin
            // A complete write pair beats a pending read.
            if (run_q && aw_full_q && w_full_q) begin
               state_d = WR;
               wr_en_d = 1'b1;
               addr_d  = aw_addr_q;
               wdata_d = w_data_q;
               wstrb_d = w_strb_q;
            end else if (ar_hs) begin
               state_d = RD;
               rd_en_d = 1'b1;
               addr_d  = REG_AW'(AXI_S_ARADDR[ADDR_WIDTH-1:2]);
            end
         end
         WR: begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            state_d   = BRESP;
         end
         BRESP: begin
            if (AXI_S_BREADY) state_d = IDLE;
            else              bvalid_d = 1'b1;
         end
         RD: begin
            state_d = RLAT;
         end
         RLAT: begin
            rdata_d  = reg_rdata;
            rvalid_d = 1'b1;
            state_d  = RRESP;
         end
         RRESP: begin
            if (AXI_S_RREADY) state_d = IDLE;
            else              rvalid_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // Readies are precomputed so the registered value matches run & ~full.
      awready_d = ~aw_full_d;
      wready_d  = ~w_full_d;
      arready_d = (state_d == IDLE) & ~(aw_full_d & w_full_d);
   end

   assign AXI_S_AWREADY = awready_q;
   assign AXI_S_WREADY  = wready_q;
   assign AXI_S_ARREADY = arready_q;
   assign AXI_S_BVALID  = bvalid_q;
   assign AXI_S_BRESP   = AXI_RESP_OKAY;
   assign AXI_S_RVALID  = rvalid_q;
   assign AXI_S_RDATA   = rdata_q;
   assign AXI_S_RRESP   = AXI_RESP_OKAY;
   assign reg_wr_en     = wr_en_q;
   assign reg_rd_en     = rd_en_q;
   assign reg_addr      = addr_q;
   assign reg_wdata     = wdata_q;
   assign reg_wstrb     = wstrb_q;

endmodule
